// File: rtl/link_arbiter.sv
`default_nettype none
// ============================================================================
// link_arbiter: round-robin, packet-locking arbiter feeding a 2-stage link pipe
// Rev 1.0
// ============================================================================
module link_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic [1:0]                    grant_id,
  output logic                          busy
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [1:0]            owner_q, owner_d;
  logic [1:0]            grant_q, grant_d;
  logic                  v1_q, v1_d, v2_q, v2_d;
  logic                  l1_q, l1_d, l2_q, l2_d;
  logic [DATA_WIDTH-1:0] d1_q, d1_d, d2_q, d2_d;

  logic                  enable;
  logic                  found;
  logic                  accept;
  logic [1:0]            pick;
  logic [1:0]            sel;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;

  // Arbitration and handshake; ready is held low throughout reset.
  always_comb begin
    enable   = !v2_q || out_ready;
    found    = 1'b0;
    pick     = ptr_q;
    req_ready = '0;
    sel_data = '0;
    sel_last = 1'b0;

    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[ptr_q + 2'(k)]) begin
        found = 1'b1;
        pick  = ptr_q + 2'(k);
      end
    end

    sel = (state_q == ST_LOCKED) ? owner_q : pick;

    if (!rst) begin
      if (state_q == ST_LOCKED) begin
        req_ready[owner_q] = enable;
      end else if (found) begin
        req_ready[pick] = enable;
      end
    end

    accept = |(req_ready & req_valid);

    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == 2'(i)) begin
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last = req_last[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    v1_d    = v1_q;
    d1_d    = d1_q;
    l1_d    = l1_q;
    v2_d    = v2_q;
    d2_d    = d2_q;
    l2_d    = l2_q;

    if (enable) begin
      v1_d = accept;
      if (accept) begin
        d1_d = sel_data;
        l1_d = sel_last;
      end
      v2_d = v1_q;
      d2_d = d1_q;
      l2_d = l1_q;
    end

    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          grant_d = pick;
          if (sel_last) begin
            ptr_d = pick + 2'd1;
          end else begin
            state_d = ST_LOCKED;
            owner_d = pick;
          end
        end
        ST_LOCKED: begin
          if (sel_last) begin
            state_d = ST_IDLE;
            ptr_d   = owner_q + 2'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      v1_q    <= 1'b0;
      d1_q    <= '0;
      l1_q    <= 1'b0;
      v2_q    <= 1'b0;
      d2_q    <= '0;
      l2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      v1_q    <= v1_d;
      d1_q    <= d1_d;
      l1_q    <= l1_d;
      v2_q    <= v2_d;
      d2_q    <= d2_d;
      l2_q    <= l2_d;
    end
  end

  assign out_valid = v2_q;
  assign out_data  = d2_q;
  assign out_last  = l2_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q == ST_LOCKED) || v1_q || v2_q;

endmodule
`default_nettype wire
